xpb_lut_mlane: RTL and testbench
================================

Name: xpb_lut_mlane

Overview:
- Runtime-loadable, multi-lane XPB (x·p·b reduction constant) lookup table for the modular-squaring datapath; replaces fixed, hard-coded per-slice constant tables.
- Host streams table entries in once through a narrow load port.
- NUM_LANES independent lookup lanes each return one WIDTH-bit constant per cycle, with a valid tag, for the reduction adder tree.

Parameters:
- WIDTH, 1024: bits per table entry.
- ADDR_W, 5: index width; the table holds 2**ADDR_W entries.
- NUM_LANES, 4: parallel lookup lanes.
- LOAD_W, 64: load beat width. WIDTH must be a multiple of LOAD_W. BEATS = WIDTH/LOAD_W (16 at defaults).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- lkp_valid  in  NUM_LANES  per-lane lookup request
- lkp_idx  in  NUM_LANES*ADDR_W  lane i index at [i*ADDR_W +: ADDR_W]
- out_valid  out  NUM_LANES  per-lane result valid
- out_data  out  NUM_LANES*WIDTH  lane i result at [i*WIDTH +: WIDTH]
- load_valid  in  1  load beat valid
- load_ready  out  1  load beat accepted when load_valid && load_ready
- load_addr  in  ADDR_W  target entry; sampled on the first beat only
- load_data  in  LOAD_W  beat payload; beat 0 fills the LSBs
- load_last  in  1  marks the final beat of an entry
- load_err  out  1  one-cycle pulse on a malformed entry
- tbl_full  out  1  every entry 1..2**ADDR_W-1 has been loaded at least once

Behaviour:
- Reset values: out_valid=0, out_data=0, load_err=0, tbl_full=0, load_ready=1, FSM=IDLE, valid bitmap cleared. Table RAM contents are not reset.
- Lookup latency is 1 cycle:
  - out_valid[i] <= lkp_valid[i].
  - out_data lane i <= table[idx] if idx != 0 and vbit[idx] is set; otherwise 0.
  - When lkp_valid[i]=0, lane data holds its previous value.
- Entry 0 always reads as 0. Loads to address 0 complete the handshake but are not written, and do not set a bit.
- Lanes are fully independent; all lanes may read the same index in the same cycle.
- Lookups are never stalled by loading.
- Read/write collision: a lookup in the COMMIT cycle to the address being committed returns the old value (or 0 if the entry was unloaded). It returns the new value from the next cycle onward.
- Load FSM states: IDLE, COLLECT, COMMIT, DRAIN.
  - IDLE (load_ready=1): on an accepted beat, capture load_addr, write the beat into staging slice 0, set cnt=1.
    - If load_last is set and BEATS>1: discard, pulse load_err, stay in IDLE.
    - If BEATS==1: go to COMMIT.
    - Otherwise go to COLLECT.
  - COLLECT (load_ready=1): each accepted beat goes into slice cnt, then cnt++.
    - load_last with cnt<BEATS-1: discard, pulse load_err, go to IDLE.
    - Beat at cnt==BEATS-1 with load_last: go to COMMIT.
    - Beat at cnt==BEATS-1 without load_last: go to DRAIN.
  - COMMIT (load_ready=0, exactly 1 cycle): table[addr] <= staging; vbit[addr] <= 1 unless addr==0; go to IDLE.
  - DRAIN (load_ready=1): swallow beats until one carries load_last; then pulse load_err and go to IDLE. Nothing is written.
- tbl_full is registered and asserts the cycle after the COMMIT that completes the bitmap. It stays high until reset.
- Reset asserted mid-load: FSM returns to IDLE, bitmap clears, the partial entry is lost, and in-flight lookups are dropped (out_valid=0).
- Elaboration must fail if WIDTH % LOAD_W != 0.

Optional Feature:
- Macro: XPB_LUT_OUT_REG_EN.
- Defined: adds a second output register stage. Lookup latency becomes 2 cycles, out_valid is delayed to match, and the COMMIT collision rule is evaluated against the first stage.
- Undefined: latency is 1 cycle as described above.
- Both builds reset all output stages to 0.

Decomposition:
- Shared package xpb_pkg holds:
  - default XPB_WIDTH=1024 and XPB_ADDR_W=5;
  - the load FSM state enum (IDLE, COLLECT, COMMIT, DRAIN);
  - a function computing BEATS.
- Sub-module xpb_load_ctrl owns the load FSM, the beat counter, the staging register, and the write strobe/address/data. The top module keeps the RAM, the bitmap and the lane read ports.

Test Plan:
- After reset, lookup idx 3 on all lanes -> out_valid=4'b1111 one cycle later and out_data all 0; tbl_full=0.
- Load addr 1 with 16 beats, beat k = 64'h1000+k, last on beat 15 -> after COMMIT, lane 2 lookup idx 1 returns the concatenation of beats 15..0.
- Load addr 5 with load_last on beat 7 -> load_err pulses once and a lookup of 5 returns 0. Then 17 beats with last on the 17th -> DRAIN, one load_err pulse, entry 5 still 0.
- Lookup idx 1 in the COMMIT cycle of a reload of addr 1 -> old value returned; the next cycle returns the new value.
- Load all 31 nonzero addresses -> tbl_full rises the cycle after the 31st COMMIT. A load to addr 0 does not change the result (idx 0 reads 0).
- Assert rst during beat 8 of a load -> load_ready=1, out_valid=0, bitmap clear. A fresh full load then succeeds. With XPB_LUT_OUT_REG_EN defined, latency is measured as 2 cycles.

Source files
------------

// File: rtl/xpb_pkg.sv
// Shared definitions for the runtime-loadable XPB lookup table: default sizes,
// load FSM states and the beats-per-entry helper.
package xpb_pkg;

  localparam int XPB_WIDTH  = 1024;
  localparam int XPB_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2,
    DRAIN   = 2'd3
  } load_state_e;

  function automatic int xpb_beats(input int width, input int load_w);
    return width / load_w;
  endfunction

endpackage

// File: rtl/xpb_lut_mlane_if.sv
// Lookup lanes and narrow load port of the XPB table, bundled for the host
// (master) and the table (slave).
interface xpb_lut_mlane_if #(
  parameter int WIDTH     = 1024,
  parameter int ADDR_W    = 5,
  parameter int NUM_LANES = 4,
  parameter int LOAD_W    = 64
);
  logic [NUM_LANES-1:0]        lkp_valid;
  logic [NUM_LANES*ADDR_W-1:0] lkp_idx;
  logic [NUM_LANES-1:0]        out_valid;
  logic [NUM_LANES*WIDTH-1:0]  out_data;
  logic                        load_valid;
  logic                        load_ready;
  logic [ADDR_W-1:0]           load_addr;
  logic [LOAD_W-1:0]           load_data;
  logic                        load_last;
  logic                        load_err;
  logic                        tbl_full;

  modport master (
    output lkp_valid, lkp_idx, load_valid, load_addr, load_data, load_last,
    input  out_valid, out_data, load_ready, load_err, tbl_full
  );

  modport slave (
    input  lkp_valid, lkp_idx, load_valid, load_addr, load_data, load_last,
    output out_valid, out_data, load_ready, load_err, tbl_full
  );
endinterface

// File: rtl/xpb_load_ctrl.sv
// Load FSM: assembles LOAD_W beats into one WIDTH-bit staged entry and issues
// a single-cycle write strobe in COMMIT; malformed entries pulse load_err.
module xpb_load_ctrl
  import xpb_pkg::*;
#(
  parameter int WIDTH  = XPB_WIDTH,
  parameter int ADDR_W = XPB_ADDR_W,
  parameter int LOAD_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LOAD_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_err,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data
);

  localparam int BEATS = xpb_beats(WIDTH, LOAD_W);
  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam bit MULTI = (BEATS > 1);

  load_state_e       state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              err_reg, err_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [WIDTH-1:0]  stage_reg;
  logic              cap_addr;
  logic              beat_we;
  logic [CNT_W-1:0]  beat_sel;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = 1'b0;
    load_ready = 1'b1;
    cap_addr   = 1'b0;
    beat_we    = 1'b0;
    beat_sel   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (load_valid) begin
          cap_addr = 1'b1;
          beat_we  = 1'b1;
          beat_sel = '0;
          cnt_next = CNT_W'(1);
          if (load_last && MULTI) begin
            err_next = 1'b1;
          end else if (!MULTI) begin
            state_next = COMMIT;
          end else begin
            state_next = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (load_valid) begin
          beat_we  = 1'b1;
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(BEATS - 1)) begin
            state_next = load_last ? COMMIT : DRAIN;
          end else if (load_last) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      COMMIT: begin
        load_ready = 1'b0;
        state_next = IDLE;
      end
      DRAIN: begin
        // An over-long entry is swallowed whole so the host stays framed.
        if (load_valid && load_last) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_addr) addr_reg <= load_addr;
    if (beat_we) stage_reg[int'(beat_sel)*LOAD_W +: LOAD_W] <= load_data;
  end

  assign load_err = err_reg;
  assign wr_en    = (state_reg == COMMIT);
  assign wr_addr  = addr_reg;
  assign wr_data  = stage_reg;

endmodule

// File: rtl/xpb_lut_mlane.sv
// Multi-lane runtime-loadable XPB lookup table. Define XPB_LUT_OUT_REG_EN to
// add a second output register stage (lookup latency 2 instead of 1).
module xpb_lut_mlane
  import xpb_pkg::*;
#(
  parameter int WIDTH     = XPB_WIDTH,
  parameter int ADDR_W    = XPB_ADDR_W,
  parameter int NUM_LANES = 4,
  parameter int LOAD_W    = 64
) (
  input  logic            clk,
  input  logic            rst,
  xpb_lut_mlane_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  if (WIDTH % LOAD_W != 0) begin : g_bad_width
    $error("xpb_lut_mlane: WIDTH must be a multiple of LOAD_W");
  end

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [DEPTH-1:0]  vbit_reg, vbit_next;
  logic              full_reg;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [NUM_LANES-1:0]            lane_valid;
  logic [NUM_LANES-1:0][WIDTH-1:0] lane_data;

  xpb_load_ctrl #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W),
    .LOAD_W (LOAD_W)
  ) u_load_ctrl (
    .clk        (clk),
    .rst        (rst),
    .load_valid (bus.load_valid),
    .load_addr  (bus.load_addr),
    .load_data  (bus.load_data),
    .load_last  (bus.load_last),
    .load_ready (bus.load_ready),
    .load_err   (bus.load_err),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  always_comb begin
    vbit_next = vbit_reg;
    if (wr_en && (wr_addr != '0)) vbit_next[wr_addr] = 1'b1;
  end

  // tbl_full looks at the post-commit bitmap so it rises right after COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vbit_reg <= '0;
      full_reg <= 1'b0;
    end else begin
      vbit_reg <= vbit_next;
      full_reg <= full_reg | (&vbit_next[DEPTH-1:1]);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr != '0)) mem[wr_addr] <= wr_data;
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [ADDR_W-1:0] idx;
    logic              hit;
    logic              v1_reg;
    logic [WIDTH-1:0]  d1_reg;

    assign idx = bus.lkp_idx[gi*ADDR_W +: ADDR_W];
    assign hit = (idx != '0) && vbit_reg[idx];

    // Reads in the COMMIT cycle see the pre-write RAM and bitmap.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v1_reg <= 1'b0;
        d1_reg <= '0;
      end else begin
        v1_reg <= bus.lkp_valid[gi];
        if (bus.lkp_valid[gi]) d1_reg <= hit ? mem[idx] : '0;
      end
    end

`ifdef XPB_LUT_OUT_REG_EN
    logic             v2_reg;
    logic [WIDTH-1:0] d2_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v2_reg <= 1'b0;
        d2_reg <= '0;
      end else begin
        v2_reg <= v1_reg;
        if (v1_reg) d2_reg <= d1_reg;
      end
    end

    assign lane_valid[gi] = v2_reg;
    assign lane_data[gi]  = d2_reg;
`else
    assign lane_valid[gi] = v1_reg;
    assign lane_data[gi]  = d1_reg;
`endif
  end

  assign bus.out_valid = lane_valid;
  assign bus.out_data  = lane_data;
  assign bus.tbl_full  = full_reg;

endmodule

// File: tb/tb_xpb_lut_mlane.sv
// Scoreboard bench for xpb_lut_mlane: lookups push expected lane results,
// a negedge monitor pops and compares them when out_valid appears.
module tb_xpb_lut_mlane;

  localparam int WIDTH = 1024;
  localparam int ADDR_W = 5;
  localparam int NL = 4;
  localparam int LOAD_W = 64;
`ifdef XPB_LUT_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int               lane;
    int               idx;
    int               due;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   err_pulses = 0;
  exp_t sbq[$];
  logic [WIDTH-1:0] ref_mem [32];
  bit               ref_v [32];

  xpb_lut_mlane_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NUM_LANES(NL), .LOAD_W(LOAD_W)) bus ();

  xpb_lut_mlane #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NUM_LANES(NL), .LOAD_W(LOAD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic logic [WIDTH-1:0] mk(input logic [63:0] base);
    logic [WIDTH-1:0] r;
    for (int k = 0; k < WIDTH / LOAD_W; k++) r[k*LOAD_W +: LOAD_W] = base + 64'(k);
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] exp_rd(input int idx);
    if (idx != 0 && ref_v[idx]) return ref_mem[idx];
    return '0;
  endfunction

  // Monitor: one comparison per presented lane result.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.load_err) err_pulses++;
      for (int l = 0; l < NL; l++) begin
        if (bus.out_valid[l]) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL lane%0d unexpected out_valid at cycle %0d", l, cyc);
          end else begin
            exp_t e;
            logic [WIDTH-1:0] got;
            e = sbq.pop_front();
            got = bus.out_data[l*WIDTH +: WIDTH];
            if (e.lane != l || e.due != cyc || got !== e.data) begin
              errors++;
              $display("FAIL lane%0d idx%0d: got lane%0d cyc%0d lo=%h hi=%h expected lane%0d cyc%0d lo=%h hi=%h",
                       l, e.idx, l, cyc, got[63:0], got[WIDTH-1 -: 64],
                       e.lane, e.due, e.data[63:0], e.data[WIDTH-1 -: 64]);
            end else begin
              $display("ok   lane%0d idx%0d cyc%0d lo=%h hi=%h", l, e.idx, cyc, got[63:0], got[WIDTH-1 -: 64]);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One lookup cycle; expectations come from the reference table as it stands now.
  task automatic lookup(input logic [NL-1:0] mask, input int i0, input int i1, input int i2, input int i3);
    int ids[NL];
    ids = '{i0, i1, i2, i3};
    for (int l = 0; l < NL; l++) begin
      bus.lkp_idx[l*ADDR_W +: ADDR_W] = ADDR_W'(ids[l]);
      if (mask[l]) sbq.push_back('{lane: l, idx: ids[l], due: cyc + LAT, data: exp_rd(ids[l])});
    end
    bus.lkp_valid = mask;
    step();
    bus.lkp_valid = '0;
  endtask

  // Streams nbeats beats (base+k), load_last on beat last_at; returns in the cycle after the final beat.
  task automatic load_entry(input int addr, input int nbeats, input int last_at, input logic [63:0] base);
    for (int k = 0; k < nbeats; k++) begin
      int guard;
      bus.load_valid = 1'b1;
      bus.load_addr  = ADDR_W'(addr);
      bus.load_data  = base + 64'(k);
      bus.load_last  = (k == last_at);
      guard = 0;
      while (!bus.load_ready && guard < 20) begin
        step();
        guard++;
      end
      if (guard >= 20) begin
        checks++;
        errors++;
        $display("FAIL load_ready timeout addr%0d beat%0d", addr, k);
      end
      step();
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic commit_model(input int addr, input logic [63:0] base);
    if (addr != 0) begin
      ref_mem[addr] = mk(base);
      ref_v[addr]   = 1'b1;
    end
  endtask

  initial begin
    int e0;
    for (int a = 0; a < 32; a++) ref_v[a] = 1'b0;
    bus.lkp_valid  = '0;
    bus.lkp_idx    = '0;
    bus.load_valid = 1'b0;
    bus.load_addr  = '0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset out_valid", 64'(bus.out_valid), 64'h0);
    chk("reset load_ready", 64'(bus.load_ready), 64'h1);
    chk("reset load_err", 64'(bus.load_err), 64'h0);
    chk("reset tbl_full", 64'(bus.tbl_full), 64'h0);
    chk("reset out_data lo", bus.out_data[63:0], 64'h0);

    lookup(4'b1111, 3, 3, 3, 3);

    // addr 1: beats 0x1000..0x100f
    load_entry(1, 16, 15, 64'h1000);
    chk("commit load_ready", 64'(bus.load_ready), 64'h0);
    step();
    commit_model(1, 64'h1000);
    lookup(4'b0100, 0, 0, 1, 0);

    // short entry then over-long entry to addr 5
    e0 = err_pulses;
    load_entry(5, 8, 7, 64'h5000);
    step(); step();
    chk("short load_err pulses", 64'(err_pulses - e0), 64'h1);
    lookup(4'b0001, 5, 0, 0, 0);
    e0 = err_pulses;
    load_entry(5, 17, 16, 64'h5000);
    step(); step();
    chk("drain load_err pulses", 64'(err_pulses - e0), 64'h1);
    lookup(4'b1011, 5, 1, 0, 5);

    // reload addr 1: COMMIT-cycle lookup sees old data, next cycle the new
    load_entry(1, 16, 15, 64'h9000);
    lookup(4'b1010, 0, 1, 0, 1);
    commit_model(1, 64'h9000);
    lookup(4'b1111, 1, 1, 1, 1);

    // fill 2..31; tbl_full rises right after the 31st COMMIT
    for (int a = 2; a < 32; a++) begin
      load_entry(a, 16, 15, 64'(a) * 64'h1000);
      if (a == 31) chk("tbl_full before last commit", 64'(bus.tbl_full), 64'h0);
      step();
      commit_model(a, 64'(a) * 64'h1000);
    end
    chk("tbl_full after last commit", 64'(bus.tbl_full), 64'h1);
    lookup(4'b1111, 31, 5, 2, 17);

    load_entry(0, 16, 15, 64'hF000);
    step();
    lookup(4'b1111, 0, 0, 31, 0);
    chk("tbl_full after addr0 load", 64'(bus.tbl_full), 64'h1);

    // reset during beat 8 of a load, with a lookup in flight
    for (int k = 0; k < 8; k++) begin
      bus.load_valid = 1'b1;
      bus.load_addr  = 5'd7;
      bus.load_data  = 64'hE000 + 64'(k);
      bus.load_last  = 1'b0;
      if (k == 7) begin
        bus.lkp_idx   = {4{5'd1}};
        bus.lkp_valid = 4'b1111;
      end
      step();
    end
    bus.lkp_valid = '0;
    bus.load_data = 64'hE008;
    #1 rst = 1'b1;
    sbq.delete();
    #1;
    chk("mid-load reset load_ready", 64'(bus.load_ready), 64'h1);
    chk("mid-load reset out_valid", 64'(bus.out_valid), 64'h0);
    chk("mid-load reset tbl_full", 64'(bus.tbl_full), 64'h0);
    bus.load_valid = 1'b0;
    for (int a = 0; a < 32; a++) ref_v[a] = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    lookup(4'b1111, 1, 7, 31, 9);
    load_entry(9, 16, 15, 64'hA000);
    step();
    commit_model(9, 64'hA000);
    lookup(4'b0110, 0, 9, 9, 0);

    repeat (LAT + 3) step();
    chk("scoreboard drained", 64'(sbq.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
